// File: rtl/keypad_pkg.sv
// Key-code constants, entry-state encoding and digit classifier shared by the
// keypad scanner, operand entry and display stages.
package keypad_pkg;

   localparam logic [3:0] KEY_NONE  = 4'hF;
   localparam logic [3:0] KEY_NEXT  = 4'hA;
   localparam logic [3:0] KEY_BACK  = 4'hC;
   localparam logic [3:0] KEY_CLEAR = 4'hD;
   localparam logic [3:0] KEY_ENTER = 4'hE;

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      DONE    = 2'd2
   } entry_state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/key_event.sv
// Press detector: one key_evt pulse per press, registered one edge after the
// first non-idle sample; re-arms only after RELEASE_CYCLES idle samples in a row.
module key_event
   import keypad_pkg::*;
#(
   parameter int RELEASE_CYCLES = 216_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_code,
   output logic       key_evt,
   output logic [3:0] evt_code
);

   localparam int RW = $clog2(RELEASE_CYCLES + 1);
   localparam logic [RW-1:0] REL_MAX = RW'(RELEASE_CYCLES);

   logic          armed;
   logic [RW-1:0] rel_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         armed    <= 1'b1;
         rel_cnt  <= '0;
         key_evt  <= 1'b0;
         evt_code <= KEY_NONE;
      end else begin
         key_evt <= 1'b0;
         if (key_code != KEY_NONE) begin
            rel_cnt <= '0;
            if (armed) begin
               key_evt  <= 1'b1;
               evt_code <= key_code;
               armed    <= 1'b0;
            end
         end else begin
            if (rel_cnt < REL_MAX)
               rel_cnt <= rel_cnt + 1'b1;
            // this idle sample completes the release window
            if (rel_cnt >= REL_MAX - 1'b1)
               armed <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/operand_entry.sv
// Key stream to BCD operand pair, 2 edges key-to-output; pair_valid holds until pair_ready.
// Backspace (4'hC) is built only when OPERAND_ENTRY_BACKSPACE_EN is defined.
module operand_entry
   import keypad_pkg::*;
#(
   parameter int MAX_DIGITS     = 3,
   parameter int RELEASE_CYCLES = 216_000
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [3:0]                        key_code,
   output logic [4*MAX_DIGITS-1:0]           operand_a,
   output logic [4*MAX_DIGITS-1:0]           operand_b,
   output logic                              active_b,
   output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
   output logic                              pair_valid,
   input  logic                              pair_ready
);

   localparam int W  = 4 * MAX_DIGITS;
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

   logic         key_evt;
   logic [3:0]   evt_code;
   entry_state_t state;

   key_event #(
      .RELEASE_CYCLES(RELEASE_CYCLES)
   ) u_key_event (
      .clk     (clk),
      .reset   (reset),
      .key_code(key_code),
      .key_evt (key_evt),
      .evt_code(evt_code)
   );

   function automatic logic [W-1:0] shift_in(input logic [W-1:0] op, input logic [3:0] d);
      return (op << 4) | {{(W-4){1'b0}}, d};
   endfunction

   assign active_b   = (state == ENTER_B);
   assign pair_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ENTER_A;
         operand_a   <= '0;
         operand_b   <= '0;
         digit_count <= '0;
      end else if (key_evt && evt_code == KEY_CLEAR) begin
         // clear outranks a same-cycle handshake: the pair is dropped, not transferred
         state       <= ENTER_A;
         operand_a   <= '0;
         operand_b   <= '0;
         digit_count <= '0;
      end else begin
         case (state)
            ENTER_A, ENTER_B: begin
               if (key_evt) begin
                  if (is_digit(evt_code)) begin
                     if (digit_count < CNT_MAX) begin
                        if (state == ENTER_B)
                           operand_b <= shift_in(operand_b, evt_code);
                        else
                           operand_a <= shift_in(operand_a, evt_code);
                        digit_count <= digit_count + 1'b1;
                     end
                  end else if (evt_code == KEY_NEXT && state == ENTER_A) begin
                     state       <= ENTER_B;
                     digit_count <= '0;
                  end else if (evt_code == KEY_ENTER && state == ENTER_B && digit_count != '0) begin
                     state <= DONE;
                  end
`ifdef OPERAND_ENTRY_BACKSPACE_EN
                  else if (evt_code == KEY_BACK && digit_count != '0) begin
                     if (state == ENTER_B)
                        operand_b <= operand_b >> 4;
                     else
                        operand_a <= operand_a >> 4;
                     digit_count <= digit_count - 1'b1;
                  end
`endif
               end
            end
            DONE: begin
               if (pair_ready) begin
                  state       <= ENTER_A;
                  operand_a   <= '0;
                  operand_b   <= '0;
                  digit_count <= '0;
               end
            end
            default: state <= ENTER_A;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry with MAX_DIGITS=3, RELEASE_CYCLES=4; expectations come
// from a digit-list model of the calculator entry rules.
module tb_operand_entry;
   import keypad_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  key_code = 4'hF;
   logic [11:0] operand_a, operand_b;
   logic        active_b, pair_valid;
   logic [1:0]  digit_count;
   logic        pair_ready = 1'b0;

   int total = 0;
   int bad = 0;

   int unsigned qa[$];
   int unsigned qb[$];
   int phase = 0;   // 0: typing A, 1: typing B, 2: pair complete

   always #5 clk = ~clk;

   operand_entry #(.MAX_DIGITS(3), .RELEASE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .key_code(key_code),
      .operand_a(operand_a), .operand_b(operand_b), .active_b(active_b),
      .digit_count(digit_count), .pair_valid(pair_valid), .pair_ready(pair_ready)
   );

   function automatic logic [11:0] exp_a();
      logic [11:0] v = 12'h0;
      foreach (qa[i]) v = v * 16 + 12'(qa[i]);
      return v;
   endfunction

   function automatic logic [11:0] exp_b();
      logic [11:0] v = 12'h0;
      foreach (qb[i]) v = v * 16 + 12'(qb[i]);
      return v;
   endfunction

   function automatic logic [1:0] exp_cnt();
      return (phase == 0) ? 2'(qa.size()) : 2'(qb.size());
   endfunction

   task automatic model_clear();
      qa.delete();
      qb.delete();
      phase = 0;
   endtask

   task automatic model_key(input logic [3:0] c);
      if (c == KEY_CLEAR) model_clear();
      else if (phase == 0) begin
         if (c <= 4'd9 && qa.size() < 3) qa.push_back(int'(c));
         else if (c == KEY_NEXT) phase = 1;
`ifdef OPERAND_ENTRY_BACKSPACE_EN
         else if (c == KEY_BACK && qa.size() > 0) void'(qa.pop_back());
`endif
      end else if (phase == 1) begin
         if (c <= 4'd9 && qb.size() < 3) qb.push_back(int'(c));
         else if (c == KEY_ENTER && qb.size() > 0) phase = 2;
`ifdef OPERAND_ENTRY_BACKSPACE_EN
         else if (c == KEY_BACK && qb.size() > 0) void'(qb.pop_back());
`endif
      end
   endtask

   // one press: code held for 'hold' cycles, then idle 'gap' cycles
   task automatic press(input logic [3:0] c, input int hold, input int gap);
      key_code = c;
      repeat (hold) @(negedge clk);
      key_code = KEY_NONE;
      repeat (gap) @(negedge clk);
      model_key(c);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      key_code = KEY_NONE;
      pair_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_clear();
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++; if (operand_a !== 12'h0) begin bad++; $display("FAIL reset_a got=%h exp=000", operand_a); end
      total++; if (operand_b !== 12'h0) begin bad++; $display("FAIL reset_b got=%h exp=000", operand_b); end
      total++; if (active_b !== 1'b0) begin bad++; $display("FAIL reset_active_b got=%b exp=0", active_b); end
      total++; if (digit_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", digit_count); end
      total++; if (pair_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pair_valid); end
      reset = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_basic();
      press(4'h1, 1, 5); press(4'h2, 2, 5); press(4'h3, 1, 5);
      press(KEY_NEXT, 1, 5); press(4'h4, 1, 5); press(4'h5, 3, 5);
      total++; if (active_b !== 1'b1) begin bad++; $display("FAIL basic_active_b got=%b exp=1", active_b); end
      key_code = KEY_ENTER;
      @(negedge clk);
      key_code = KEY_NONE;
      total++; if (pair_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_early got=%b exp=0", pair_valid); end
      @(negedge clk);
      total++; if (pair_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_edge2 got=%b exp=1", pair_valid); end
      repeat (4) @(negedge clk);
      model_key(KEY_ENTER);
      total++; if (operand_a !== 12'h123) begin bad++; $display("FAIL basic_a got=%h exp=123", operand_a); end
      total++; if (operand_b !== 12'h045) begin bad++; $display("FAIL basic_b got=%h exp=045", operand_b); end
   endtask

   task automatic test_done_hold();
      press(4'h6, 1, 5);
      press(4'h8, 2, 5);
      total++; if (pair_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", pair_valid); end
      total++; if (operand_a !== 12'h123) begin bad++; $display("FAIL hold_a got=%h exp=123", operand_a); end
      total++; if (operand_b !== 12'h045) begin bad++; $display("FAIL hold_b got=%h exp=045", operand_b); end
      pair_ready = 1'b1;
      @(negedge clk);
      pair_ready = 1'b0;
      phase = (phase == 2) ? 0 : phase;
      qa.delete(); qb.delete();
      total++; if (pair_valid !== 1'b0) begin bad++; $display("FAIL xfer_valid got=%b exp=0", pair_valid); end
      total++; if (operand_a !== 12'h0 || operand_b !== 12'h0) begin bad++; $display("FAIL xfer_ops got=%h/%h exp=000/000", operand_a, operand_b); end
      total++; if (active_b !== 1'b0) begin bad++; $display("FAIL xfer_active_b got=%b exp=0", active_b); end
      // ready while idle must not disturb entry
      pair_ready = 1'b1;
      press(4'h5, 1, 5);
      pair_ready = 1'b0;
      total++; if (operand_a !== 12'h005) begin bad++; $display("FAIL ready_idle_a got=%h exp=005", operand_a); end
   endtask

   task automatic test_held_key();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         key_code = 4'h7;
         repeat (4) @(negedge clk);
         key_code = KEY_NONE;
         repeat (3) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      model_key(4'h7);
      total++; if (operand_a !== 12'h007) begin bad++; $display("FAIL held_a got=%h exp=007", operand_a); end
      total++; if (digit_count !== 2'd1) begin bad++; $display("FAIL held_count got=%0d exp=1", digit_count); end
   endtask

   task automatic test_overflow();
      do_reset();
      press(4'h9, 1, 5); press(4'h8, 1, 5); press(4'h7, 1, 5); press(4'h6, 1, 5);
      total++; if (operand_a !== 12'h987) begin bad++; $display("FAIL ovf_a got=%h exp=987", operand_a); end
      total++; if (digit_count !== 2'd3) begin bad++; $display("FAIL ovf_count got=%0d exp=3", digit_count); end
   endtask

   task automatic test_clear();
      do_reset();
      press(4'h1, 1, 5); press(4'h2, 1, 5); press(KEY_NEXT, 1, 5); press(4'h3, 1, 5);
      total++; if (operand_a !== 12'h012 || operand_b !== 12'h003) begin bad++; $display("FAIL clr_pre got=%h/%h exp=012/003", operand_a, operand_b); end
      press(KEY_CLEAR, 1, 5);
      total++; if (operand_a !== 12'h0 || operand_b !== 12'h0) begin bad++; $display("FAIL clr_ops got=%h/%h exp=000/000", operand_a, operand_b); end
      total++; if (active_b !== 1'b0) begin bad++; $display("FAIL clr_active_b got=%b exp=0", active_b); end
      press(KEY_NEXT, 1, 5); press(4'h7, 1, 5); press(KEY_ENTER, 1, 5);
      total++; if (pair_valid !== 1'b1) begin bad++; $display("FAIL rst_done_pre got=%b exp=1", pair_valid); end
      reset = 1'b1;
      @(negedge clk);
      total++; if ({operand_a, operand_b, active_b, digit_count, pair_valid} !== 28'h0) begin
         bad++; $display("FAIL rst_done got=%h/%h/%b/%0d/%b exp=all zero", operand_a, operand_b, active_b, digit_count, pair_valid);
      end
      reset = 1'b0;
      model_clear();
      repeat (5) @(negedge clk);
   endtask

   task automatic test_backspace();
      do_reset();
      press(4'h4, 1, 5); press(4'h5, 1, 5); press(4'h6, 1, 5); press(KEY_BACK, 1, 5);
`ifdef OPERAND_ENTRY_BACKSPACE_EN
      total++; if (operand_a !== 12'h045) begin bad++; $display("FAIL bksp_a got=%h exp=045", operand_a); end
      total++; if (digit_count !== 2'd2) begin bad++; $display("FAIL bksp_count got=%0d exp=2", digit_count); end
`else
      total++; if (operand_a !== 12'h456) begin bad++; $display("FAIL bksp_a got=%h exp=456", operand_a); end
      total++; if (digit_count !== 2'd3) begin bad++; $display("FAIL bksp_count got=%0d exp=3", digit_count); end
`endif
   endtask

   task automatic test_random();
      logic [3:0] c;
      int r;
      do_reset();
      for (int n = 0; n < 120; n++) begin
         r = $urandom_range(0, 17);
         if (r <= 9) c = 4'(r);
         else if (r == 10 || r == 11) c = KEY_NEXT;
         else if (r == 12) c = 4'hB;
         else if (r == 13) c = KEY_BACK;
         else if (r == 14) c = KEY_CLEAR;
         else c = KEY_ENTER;
         press(c, $urandom_range(1, 3), $urandom_range(4, 6));
         if ($urandom_range(0, 3) == 0) begin
            pair_ready = 1'b1;
            @(negedge clk);
            pair_ready = 1'b0;
            if (phase == 2) model_clear();
         end
         total++; if (operand_a !== exp_a()) begin bad++; $display("FAIL rand_a n=%0d got=%h exp=%h", n, operand_a, exp_a()); end
         total++; if (operand_b !== exp_b()) begin bad++; $display("FAIL rand_b n=%0d got=%h exp=%h", n, operand_b, exp_b()); end
         total++; if (digit_count !== exp_cnt()) begin bad++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, digit_count, exp_cnt()); end
         total++; if (active_b !== (phase == 1)) begin bad++; $display("FAIL rand_active_b n=%0d got=%b exp=%b", n, active_b, phase == 1); end
         total++; if (pair_valid !== (phase == 2)) begin bad++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, pair_valid, phase == 2); end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_done_hold();
      test_held_key();
      test_overflow();
      test_clear();
      test_backspace();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
